// File: rtl/regfile_pkg.sv
// Shared types and constants for the 31 x 64-bit architectural register file.
package regfile_pkg;
  localparam int NUM_REGS = 31;
  localparam logic [4:0] ZERO_REG = 5'd31;
  localparam int DATA_W = 64;
  typedef logic [4:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/regfile_wb_if.sv
// Write/read bus between the pipeline and the register file.
interface regfile_wb_if #(
  parameter int DATA_W = 64
);
  logic              RegWrite;
  logic [4:0]        WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic [4:0]        ReadRegister1;
  logic [4:0]        ReadRegister2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;

  modport master (
    output RegWrite, WriteReg, WriteData, ReadRegister1, ReadRegister2,
    input  ReadData1, ReadData2
  );
  modport slave (
    input  RegWrite, WriteReg, WriteData, ReadRegister1, ReadRegister2,
    output ReadData1, ReadData2
  );
endinterface

// File: rtl/regfile_wb_decoder.sv
// Write-enable decoder: one-hot enable per stored register; index 31 has no enable.
module decoder
  import regfile_pkg::*;
(
  input  logic              RegWrite,
  input  reg_idx_t          WriteReg,
  output logic [NUM_REGS-1:0] Register
);
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_en
    assign Register[i] = RegWrite && (WriteReg == 5'(i));
  end
endmodule

// File: rtl/regfile_wb_reg_en.sv
// DATA_W-bit register with synchronous active-high reset and load enable.
module reg_en #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= en ? d : q;
  end
endmodule

// File: rtl/regfile_wb.sv
// 31 x DATA_W register file: two combinational read ports, one synchronous write port,
// index 31 reads as zero, optional same-cycle write-through to the read ports.
module regfile_wb
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter bit BYPASS = 1'b1
) (
  input logic         clk,
  input logic         reset,
  regfile_wb_if.slave bus
);
  logic [NUM_REGS-1:0] reg_we;
  logic [DATA_W-1:0]   q [NUM_REGS];
  reg_idx_t            rs [2];
  logic [DATA_W-1:0]   rd [2];

  decoder u_dec (
    .RegWrite (bus.RegWrite),
    .WriteReg (bus.WriteReg),
    .Register (reg_we)
  );

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    reg_en #(.DATA_W(DATA_W)) u_reg (
      .clk   (clk),
      .reset (reset),
      .en    (reg_we[i]),
      .d     (bus.WriteData),
      .q     (q[i])
    );
  end

  assign rs[0] = bus.ReadRegister1;
  assign rs[1] = bus.ReadRegister2;

  for (genvar p = 0; p < 2; p++) begin : g_port
    // Heap-ordered mux tree: nodes 0..30 are 2:1 muxes, nodes 31..62 are the 32 inputs.
    logic [DATA_W-1:0] node [63];
    logic              byp;

    for (genvar i = 0; i < 32; i++) begin : g_leaf
      if (i < NUM_REGS) begin : g_stored
        assign node[31+i] = q[i];
      end else begin : g_zero
        assign node[31+i] = '0;
      end
    end

    for (genvar k = 0; k < 31; k++) begin : g_mux
      localparam int SB = 5 - $clog2(k + 2);
      assign node[k] = rs[p][SB] ? node[2*k+2] : node[2*k+1];
    end

    assign byp   = BYPASS && !reset && bus.RegWrite &&
                   (bus.WriteReg == rs[p]) && (rs[p] != ZERO_REG);
    assign rd[p] = byp ? bus.WriteData : node[0];
  end

  assign bus.ReadData1 = rd[0];
  assign bus.ReadData2 = rd[1];
endmodule

// File: tb/tb_regfile_wb.sv
// Bench for regfile_wb: BYPASS=1 and BYPASS=0 instances driven in lockstep against an array model.
module tb_regfile_wb;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] mdl [32];
  bit   known = 1'b0;

  always #5 clk = ~clk;

  regfile_wb_if #(.DATA_W(64)) bus1 ();
  regfile_wb_if #(.DATA_W(64)) bus0 ();

  regfile_wb #(.DATA_W(64), .BYPASS(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  regfile_wb #(.DATA_W(64), .BYPASS(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

  function automatic logic [63:0] ref_rd(bit byp, bit rst, bit we, logic [4:0] wr,
                                         logic [63:0] wd, logic [4:0] idx);
    if (idx == 5'd31) return 64'd0;
    if (byp && !rst && we && wr == idx) return wd;
    return mdl[idx];
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reads(string tag, bit rst, bit we, logic [4:0] wr, logic [63:0] wd,
                             logic [4:0] r1, logic [4:0] r2);
    check({tag, " b1.rd1"}, bus1.ReadData1, ref_rd(1'b1, rst, we, wr, wd, r1));
    check({tag, " b1.rd2"}, bus1.ReadData2, ref_rd(1'b1, rst, we, wr, wd, r2));
    check({tag, " b0.rd1"}, bus0.ReadData1, ref_rd(1'b0, rst, we, wr, wd, r1));
    check({tag, " b0.rd2"}, bus0.ReadData2, ref_rd(1'b0, rst, we, wr, wd, r2));
  endtask

  // Drive one cycle, check reads before and after the rising edge.
  task automatic step(string tag, bit rst, bit we, logic [4:0] wr, logic [63:0] wd,
                      logic [4:0] r1, logic [4:0] r2);
    reset = rst;
    bus1.RegWrite = we;      bus0.RegWrite = we;
    bus1.WriteReg = wr;      bus0.WriteReg = wr;
    bus1.WriteData = wd;     bus0.WriteData = wd;
    bus1.ReadRegister1 = r1; bus0.ReadRegister1 = r1;
    bus1.ReadRegister2 = r2; bus0.ReadRegister2 = r2;
    #1;
    if (known) check_reads({tag, " pre"}, rst, we, wr, wd, r1, r2);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl[i] = 64'd0;
      known = 1'b1;
    end else if (we && wr != 5'd31) begin
      mdl[wr] = wd;
    end
    #1;
    if (known) check_reads({tag, " post"}, rst, we, wr, wd, r1, r2);
  endtask

  task automatic scan(string tag);
    for (int i = 0; i < 32; i++)
      step(tag, 1'b0, 1'b0, 5'(i), 64'd0, 5'(i), 5'(31 - i));
  endtask

  initial begin
    logic [63:0] rv;
    for (int i = 0; i < 32; i++) mdl[i] = 'x;
    @(negedge clk);

    step("reset", 1'b1, 1'b1, 5'd2, 64'h55, 5'd0, 5'd1);
    scan("after_reset");
    check("zero x7 b1", bus1.ReadData1 === 64'd0 ? 64'd0 : bus1.ReadData1, mdl[7]);

    step("wr_x5", 1'b0, 1'b1, 5'd5, 64'hDEADBEEF_CAFEF00D, 5'd4, 5'd6);
    step("rd_x5", 1'b0, 1'b0, 5'd0, 64'd0, 5'd5, 5'd5);
    check("x5 literal", bus1.ReadData1, 64'hDEADBEEF_CAFEF00D);
    step("rd_x4_x6", 1'b0, 1'b0, 5'd0, 64'd0, 5'd4, 5'd6);
    check("x4 zero", bus0.ReadData1, 64'd0);

    step("wr_x31", 1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31);
    scan("after_x31");

    step("we0_x7", 1'b0, 1'b0, 5'd7, 64'h1234, 5'd7, 5'd7);
    check("x7 held", bus1.ReadData1, 64'd0);

    step("set_x9", 1'b0, 1'b1, 5'd9, 64'h11, 5'd9, 5'd0);
    reset = 1'b0;
    bus1.RegWrite = 1'b1; bus0.RegWrite = 1'b1;
    bus1.WriteReg = 5'd9; bus0.WriteReg = 5'd9;
    bus1.WriteData = 64'h22; bus0.WriteData = 64'h22;
    bus1.ReadRegister1 = 5'd9; bus0.ReadRegister1 = 5'd9;
    bus1.ReadRegister2 = 5'd9; bus0.ReadRegister2 = 5'd9;
    #1;
    check("byp1 pre", bus1.ReadData1, 64'h22);
    check("byp1 pre rd2", bus1.ReadData2, 64'h22);
    check("byp0 pre", bus0.ReadData1, 64'h11);
    step("wr_x9", 1'b0, 1'b1, 5'd9, 64'h22, 5'd9, 5'd9);
    check("byp0 post", bus0.ReadData1, 64'h22);

    // Reset with a write pending: bypass suppressed, write discarded.
    step("rst_byp", 1'b1, 1'b1, 5'd9, 64'h77, 5'd9, 5'd5);
    check("rst x9 b1", bus1.ReadData1, 64'd0);

    for (int n = 0; n < 300; n++) begin
      rv = {$urandom, $urandom};
      step("rand", ($urandom_range(0, 39) == 0), 1'($urandom), 5'($urandom),
           rv, 5'($urandom), 5'($urandom));
    end

    for (int i = 0; i < 31; i++)
      step("fill", 1'b0, 1'b1, 5'(i), 64'(i + 1), 5'(i), 5'(30 - i));
    step("rd_fill", 1'b0, 1'b0, 5'd0, 64'd0, 5'd3, 5'd30);
    check("fill x3", bus1.ReadData1, 64'd4);
    check("fill x30", bus0.ReadData2, 64'd31);
    step("rst_wr_x3", 1'b1, 1'b1, 5'd3, 64'hAA, 5'd3, 5'd3);
    check("rst x3", bus1.ReadData1, 64'd0);
    scan("after_fill_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
